// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the serial binary-to-BCD digit sequencer.
package bcd_seq_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StEmit  = 2'd2,
      StDone  = 2'd3
   } state_e;

   localparam int unsigned DigitCnt = 3;

   localparam logic [1:0] IdxH = 2'd2;
   localparam logic [1:0] IdxT = 2'd1;
   localparam logic [1:0] IdxU = 2'd0;

   // ceil(bin_w * log10(2)) with log10(2) ~= 0.30103, never fewer than the emitted digits
   function automatic int unsigned scratch_digits(input int unsigned bin_w);
      int unsigned n;
      n = (bin_w * 30103 + 99999) / 100000;
      return (n < DigitCnt) ? DigitCnt : n;
   endfunction

endpackage

// File: rtl/dd_add3.sv
// Double-dabble correction: a BCD digit of 5 or more gets 3 added before the shift.
module dd_add3 (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_digit_seq.sv
// Serial double-dabble converter that presents hundreds, tens and units one per cycle
// to a downstream BCD decoder, with optional leading-zero blanking.
module bcd_digit_seq
   import bcd_seq_pkg::*;
#(
   parameter int unsigned BIN_W    = 8,
   parameter bit          BLANK_LZ = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic [3:0]       bcd_num,
   output logic             enable,
   output logic [1:0]       digit_idx,
   output logic [3:0]       bcd_h,
   output logic [3:0]       bcd_t,
   output logic [3:0]       bcd_u
);

   localparam int unsigned ND = scratch_digits(BIN_W);
   localparam int unsigned SW = 4 * ND;
   localparam int unsigned CW = $clog2(BIN_W + 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BIN_W-1:0] sh_q, sh_d;
   logic [SW-1:0]    scr_q, scr_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       res_h_q, res_h_d;
   logic [3:0]       res_t_q, res_t_d;
   logic [3:0]       res_u_q, res_u_d;

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [3:0]       num_q, num_d;
   logic             en_q, en_d;
   logic [1:0]       dig_idx_q, dig_idx_d;

   logic [SW-1:0]       scr_adj;
   logic [SW+BIN_W-1:0] dabble;
   logic [SW-1:0]       scr_shift;
   logic [BIN_W-1:0]    sh_shift;
   logic                lz_h, lz_t;

   for (genvar g = 0; g < ND; g++) begin : g_add3
      dd_add3 u_add3 (
         .digit_i (scr_q[4*g +: 4]),
         .digit_o (scr_adj[4*g +: 4])
      );
   end

   // Scratch and binary shift as one register so the binary MSB falls into the units digit.
   always_comb begin
      dabble    = {scr_adj, sh_q} << 1;
      scr_shift = dabble[SW+BIN_W-1:BIN_W];
      sh_shift  = dabble[BIN_W-1:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      scr_d   = scr_q;
      idx_d   = idx_q;
      res_h_d = res_h_q;
      res_t_d = res_t_q;
      res_u_d = res_u_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               sh_d    = bin_in;
               scr_d   = '0;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            scr_d = scr_shift;
            sh_d  = sh_shift;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(BIN_W - 1)) begin
               res_h_d = scr_shift[8 +: 4];
               res_t_d = scr_shift[4 +: 4];
               res_u_d = scr_shift[0 +: 4];
               idx_d   = IdxH;
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (idx_q == IdxU) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q - 2'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register cleanly on the same edge.
   always_comb begin
      busy_d    = (state_d != StIdle);
      done_d    = (state_d == StDone);
      num_d     = 4'd0;
      en_d      = 1'b0;
      dig_idx_d = 2'd0;
      lz_h      = (res_h_d == 4'd0);
      lz_t      = lz_h && (res_t_d == 4'd0);

      if (state_d == StEmit) begin
         dig_idx_d = idx_d;
         case (idx_d)
            IdxH: begin
               num_d = res_h_d;
               en_d  = !(BLANK_LZ && lz_h);
            end
            IdxT: begin
               num_d = res_t_d;
               en_d  = !(BLANK_LZ && lz_t);
            end
            default: begin
               num_d = res_u_d;
               en_d  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         sh_q      <= '0;
         scr_q     <= '0;
         idx_q     <= 2'd0;
         res_h_q   <= 4'd0;
         res_t_q   <= 4'd0;
         res_u_q   <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         num_q     <= 4'd0;
         en_q      <= 1'b0;
         dig_idx_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         scr_q     <= scr_d;
         idx_q     <= idx_d;
         res_h_q   <= res_h_d;
         res_t_q   <= res_t_d;
         res_u_q   <= res_u_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         num_q     <= num_d;
         en_q      <= en_d;
         dig_idx_q <= dig_idx_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign bcd_num   = num_q;
   assign enable    = en_q;
   assign digit_idx = dig_idx_q;
   assign bcd_h     = res_h_q;
   assign bcd_t     = res_t_q;
   assign bcd_u     = res_u_q;

endmodule
